// File: rtl/riscv_ahb3_mem_slave_if.sv
// AHB3-Lite bus bundle between a master (or interconnect mux) and the on-chip memory slave.
// HREADY is the mux-side ready, so it is driven from the master side of the bundle.
interface riscv_ahb3_mem_slave_if #(
  parameter int XLEN = 64,
  parameter int PLEN = 64
);
  logic            HSEL;
  logic [PLEN-1:0] HADDR;
  logic [XLEN-1:0] HWDATA;
  logic [XLEN-1:0] HRDATA;
  logic            HWRITE;
  logic [2:0]      HSIZE;
  logic [2:0]      HBURST;
  logic [3:0]      HPROT;
  logic [1:0]      HTRANS;
  logic            HMASTLOCK;
  logic            HREADY;
  logic            HREADYOUT;
  logic            HRESP;

  modport master (
    output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/riscv_ahb3_mem_slave.sv
// AHB3-Lite memory slave: word-organised RAM, byte-lane writes, write-to-read forwarding, 2-cycle ERROR.
// Optional feature macro RISCV_AHB3_MEM_WAIT_EN inserts WAIT_STATES wait cycles per OK transfer.
module riscv_ahb3_mem_slave #(
  parameter int XLEN        = 64,
  parameter int PLEN        = 64,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                     HRESETn,
  input  logic                     HCLK,
  riscv_ahb3_mem_slave_if.slave    ahb
);
  localparam int BW   = XLEN / 8;
  localparam int OFFW = $clog2(BW);
  localparam int IDXW = $clog2(MEM_DEPTH);
  localparam logic [PLEN-1:0] MEM_BYTES = PLEN'(MEM_DEPTH * BW);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  // A byte belongs to the access when it shares the naturally aligned 2^size block with the address.
  function automatic logic [BW-1:0] lane_mask(input logic [2:0] size, input logic [OFFW-1:0] off);
    logic [BW-1:0]   m;
    logic [OFFW-1:0] li;
    m = '0;
    for (int i = 0; i < BW; i++) begin
      li   = OFFW'(i);
      m[i] = (((li ^ off) >> size) == '0);
    end
    return m;
  endfunction

  function automatic logic misaligned(input logic [2:0] size, input logic [OFFW-1:0] off);
    logic r;
    r = 1'b0;
    for (int i = 0; i < OFFW; i++) begin
      if ((3'(i) < size) && off[i]) r = 1'b1;
    end
    return r;
  endfunction

  logic [XLEN-1:0] mem_r [MEM_DEPTH];
  state_t          state_r, state_nxt_s;
  logic            accept_s, err_s, commit_s;
  logic [IDXW-1:0] idx_s, widx_r;
  logic [BW-1:0]   mask_s, wmask_r;
  logic            write_r;
  logic [XLEN-1:0] rd_word_s, hrdata_r;
  logic            hreadyout_s, hresp_s, hreadyout_r, hresp_r;
  logic            unused_s;

  assign unused_s = ^{ahb.HBURST, ahb.HPROT, ahb.HMASTLOCK};

  // hreadyout_r is high exactly in IDLE/DATA/ERR2, the states that may take a new address phase
  assign accept_s = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1] & hreadyout_r;
  assign idx_s    = ahb.HADDR[OFFW +: IDXW];
  assign mask_s   = lane_mask(ahb.HSIZE, ahb.HADDR[OFFW-1:0]);
  assign err_s    = (ahb.HADDR >= MEM_BYTES) | (ahb.HSIZE > 3'(OFFW)) |
                    misaligned(ahb.HSIZE, ahb.HADDR[OFFW-1:0]);
  assign commit_s = (state_r == ST_DATA) & write_r;

`ifdef RISCV_AHB3_MEM_WAIT_EN
  localparam bit WAIT_ON = (WAIT_STATES != 0);
  localparam int CW      = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  logic [CW-1:0] wcnt_r;

  // Wait counter: preloaded outside WAIT, counts down while in WAIT
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                wcnt_r <= '0;
    else if (state_r != ST_WAIT) wcnt_r <= CW'(WAIT_STATES - 1);
    else if (wcnt_r != '0)       wcnt_r <= wcnt_r - 1'b1;
  end
`endif

  // State register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_r <= ST_IDLE;
    else          state_r <= state_nxt_s;
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (accept_s) begin
          if (err_s) state_nxt_s = ST_ERR1;
`ifdef RISCV_AHB3_MEM_WAIT_EN
          else if (WAIT_ON) state_nxt_s = ST_WAIT;
`endif
          else state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
`ifdef RISCV_AHB3_MEM_WAIT_EN
      ST_WAIT: begin
        if (wcnt_r == '0) state_nxt_s = ST_DATA;
        else              state_nxt_s = ST_WAIT;
      end
`endif
      ST_ERR1: state_nxt_s = ST_ERR2;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Response decode from the upcoming state, registered below
  always_comb begin
    hreadyout_s = 1'b1;
    hresp_s     = 1'b0;
    case (state_nxt_s)
      ST_WAIT: hreadyout_s = 1'b0;
      ST_ERR1: begin
        hreadyout_s = 1'b0;
        hresp_s     = 1'b1;
      end
      ST_ERR2: hresp_s = 1'b1;
      default: begin
        hreadyout_s = 1'b1;
        hresp_s     = 1'b0;
      end
    endcase
  end

  // Read word with the completing write merged in on a same-word hit
  always_comb begin
    rd_word_s = mem_r[idx_s];
    if (commit_s && (widx_r == idx_s)) begin
      for (int i = 0; i < BW; i++) begin
        if (wmask_r[i]) rd_word_s[i*8 +: 8] = ahb.HWDATA[i*8 +: 8];
        else            rd_word_s[i*8 +: 8] = mem_r[idx_s][i*8 +: 8];
      end
    end else begin
      rd_word_s = mem_r[idx_s];
    end
  end

  // Address-phase capture for the pending write
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      write_r <= 1'b0;
      widx_r  <= '0;
      wmask_r <= '0;
    end else if (accept_s) begin
      write_r <= ahb.HWRITE & ~err_s;
      widx_r  <= idx_s;
      wmask_r <= mask_s;
    end else if (commit_s) begin
      write_r <= 1'b0;
    end
  end

  // Registered bus responses
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hreadyout_r <= 1'b1;
      hresp_r     <= 1'b0;
      hrdata_r    <= '0;
    end else begin
      hreadyout_r <= hreadyout_s;
      hresp_r     <= hresp_s;
      if (accept_s && !ahb.HWRITE && !err_s) hrdata_r <= rd_word_s;
    end
  end

  // RAM array, contents not reset
  always_ff @(posedge HCLK) begin
    if (commit_s) begin
      for (int i = 0; i < BW; i++) begin
        if (wmask_r[i]) mem_r[widx_r][i*8 +: 8] <= ahb.HWDATA[i*8 +: 8];
      end
    end
  end

  assign ahb.HREADYOUT = hreadyout_r;
  assign ahb.HRESP     = hresp_r;
  assign ahb.HRDATA    = hrdata_r;
endmodule

// File: tb/tb_riscv_ahb3_mem_slave.sv
// Directed bench for riscv_ahb3_mem_slave: pipelined AHB master model, hand-computed expectations.
module tb_riscv_ahb3_mem_slave;
  localparam int XLEN       = 64;
  localparam int PLEN       = 64;
  localparam int MEM_DEPTH  = 256;
  localparam int WAIT_LIMIT = 20;
`ifdef RISCV_AHB3_MEM_WAIT_EN
  localparam int EXP_WAIT = 2;
`else
  localparam int EXP_WAIT = 0;
`endif

  logic HCLK    = 1'b0;
  logic HRESETn = 1'b0;
  logic hready_block = 1'b0;
  always #5 HCLK = ~HCLK;

  riscv_ahb3_mem_slave_if #(.XLEN(XLEN), .PLEN(PLEN)) bus ();
  assign bus.HREADY = hready_block ? 1'b0 : bus.HREADYOUT;

  riscv_ahb3_mem_slave #(.XLEN(XLEN), .PLEN(PLEN), .MEM_DEPTH(MEM_DEPTH), .WAIT_STATES(2)) dut (
    .HRESETn (HRESETn),
    .HCLK    (HCLK),
    .ahb     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic        b_write [8];
  logic [63:0] b_addr  [8];
  logic [2:0]  b_size  [8];
  logic [63:0] b_wdata [8];
  logic [63:0] r_data  [8];
  logic        r_resp  [8];
  logic        r_lo_resp [8];
  int          r_wait  [8];
  int          wait_sum;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_beat(input int i, input logic wr, input logic [63:0] addr,
                          input logic [2:0] size, input logic [63:0] wdata);
    b_write[i] = wr;
    b_addr[i]  = addr;
    b_size[i]  = size;
    b_wdata[i] = wdata;
  endtask

  // Drives n pipelined beats, then an IDLE address phase, recording each beat's data-phase result
  task automatic run_beats(input int n);
    int  lo;
    logic done;
    for (int k = 0; k <= n; k++) begin
      if (k < n) begin
        bus.HSEL   = 1'b1;
        bus.HTRANS = (k == 0) ? 2'b10 : 2'b11;
        bus.HADDR  = b_addr[k];
        bus.HWRITE = b_write[k];
        bus.HSIZE  = b_size[k];
        r_lo_resp[k] = 1'b0;
      end else begin
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b0;
      end
      if (k > 0) bus.HWDATA = b_wdata[k-1];
      lo   = 0;
      done = 1'b0;
      while (!done) begin
        @(negedge HCLK);
        if (bus.HREADYOUT) begin
          done = 1'b1;
        end else begin
          if (k > 0) r_lo_resp[k-1] = bus.HRESP;
          lo++;
          if (lo > WAIT_LIMIT) begin
            check_eq("hreadyout_timeout", 64'(lo), 64'(WAIT_LIMIT));
            done = 1'b1;
          end
        end
      end
      if (k > 0) begin
        r_data[k-1] = bus.HRDATA;
        r_resp[k-1] = bus.HRESP;
        r_wait[k-1] = lo;
      end
      @(posedge HCLK);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.HSEL = 1'b0; bus.HADDR = '0; bus.HWDATA = '0; bus.HWRITE = 1'b0;
    bus.HSIZE = 3'd0; bus.HBURST = 3'd0; bus.HPROT = 4'h3; bus.HTRANS = 2'b00;
    bus.HMASTLOCK = 1'b0;

    // reset values
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    check_eq("rst_hreadyout", 64'(bus.HREADYOUT), 64'd1);
    check_eq("rst_hresp", 64'(bus.HRESP), 64'd0);
    check_eq("rst_hrdata", bus.HRDATA, 64'd0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // write-then-read dword
    set_beat(0, 1'b1, 64'h10, 3'd3, 64'h1122334455667788); run_beats(1);
    set_beat(0, 1'b0, 64'h10, 3'd3, 64'h0); run_beats(1);
    check_eq("wr_rd_data", r_data[0], 64'h1122334455667788);
    check_eq("wr_rd_resp", 64'(r_resp[0]), 64'd0);
    check_eq("wr_rd_wait", 64'(r_wait[0]), 64'(EXP_WAIT));

    // byte lane write
    set_beat(0, 1'b1, 64'h13, 3'd0, 64'h00000000AA000000); run_beats(1);
    set_beat(0, 1'b0, 64'h10, 3'd3, 64'h0); run_beats(1);
    check_eq("byte_lane", r_data[0], 64'h11223344AA667788);

    // back-to-back halfword write and read of the same word
    set_beat(0, 1'b1, 64'h20, 3'd3, 64'hCAFEF00D12345678); run_beats(1);
    set_beat(0, 1'b1, 64'h20, 3'd1, 64'h000000000000BEEF);
    set_beat(1, 1'b0, 64'h20, 3'd3, 64'h0);
    run_beats(2);
    check_eq("raw_fwd", r_data[1], 64'hCAFEF00D1234BEEF);
    check_eq("raw_wait", 64'(r_wait[1]), 64'(EXP_WAIT));

    // INCR4 write, WRAP4 read from 0x50
    bus.HBURST = 3'b011;
    for (int i = 0; i < 4; i++) set_beat(i, 1'b1, 64'h40 + 64'(i * 8), 3'd3, 64'(i));
    run_beats(4);
    bus.HBURST = 3'b010;
    set_beat(0, 1'b0, 64'h50, 3'd3, 64'h0);
    set_beat(1, 1'b0, 64'h58, 3'd3, 64'h0);
    set_beat(2, 1'b0, 64'h40, 3'd3, 64'h0);
    set_beat(3, 1'b0, 64'h48, 3'd3, 64'h0);
    run_beats(4);
    bus.HBURST = 3'b000;
    check_eq("wrap_beat0", r_data[0], 64'd2);
    check_eq("wrap_beat1", r_data[1], 64'd3);
    check_eq("wrap_beat2", r_data[2], 64'd0);
    check_eq("wrap_beat3", r_data[3], 64'd1);
    wait_sum = 0;
    for (int i = 0; i < 4; i++) wait_sum += r_wait[i];
    check_eq("wrap_wait_total", 64'(wait_sum), 64'(4 * EXP_WAIT));

    // error responses; word 0 must survive the misaligned write
    set_beat(0, 1'b1, 64'h0, 3'd3, 64'h0123456789ABCDEF); run_beats(1);
    set_beat(0, 1'b0, 64'(MEM_DEPTH * 8), 3'd3, 64'h0); run_beats(1);
    check_eq("oob_err1_resp", 64'(r_lo_resp[0]), 64'd1);
    check_eq("oob_err_wait", 64'(r_wait[0]), 64'd1);
    check_eq("oob_err2_resp", 64'(r_resp[0]), 64'd1);
    set_beat(0, 1'b1, 64'h02, 3'd2, 64'hFFFFFFFFFFFFFFFF); run_beats(1);
    check_eq("misalign_err1_resp", 64'(r_lo_resp[0]), 64'd1);
    check_eq("misalign_err_wait", 64'(r_wait[0]), 64'd1);
    check_eq("misalign_err2_resp", 64'(r_resp[0]), 64'd1);
    set_beat(0, 1'b0, 64'h0, 3'd4, 64'h0); run_beats(1);
    check_eq("size_err_resp", 64'(r_resp[0]), 64'd1);
    set_beat(0, 1'b0, 64'h0, 3'd3, 64'h0); run_beats(1);
    check_eq("err_ram_unchanged", r_data[0], 64'h0123456789ABCDEF);
    check_eq("post_err_resp", 64'(r_resp[0]), 64'd0);

    // BUSY and IDLE stay zero-wait OKAY
    bus.HSEL = 1'b1; bus.HTRANS = 2'b01;
    @(posedge HCLK); #1;
    bus.HTRANS = 2'b00;
    @(negedge HCLK);
    check_eq("busy_hreadyout", 64'(bus.HREADYOUT), 64'd1);
    check_eq("busy_hresp", 64'(bus.HRESP), 64'd0);
    @(posedge HCLK); #1;
    @(negedge HCLK);
    check_eq("idle_hreadyout", 64'(bus.HREADYOUT), 64'd1);
    @(posedge HCLK); #1;

    // HREADY low from another slave: transfer must be ignored
    hready_block = 1'b1;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = 64'h0; bus.HSIZE = 3'd3;
    @(posedge HCLK); #1;
    bus.HTRANS = 2'b00; bus.HSEL = 1'b0; bus.HWRITE = 1'b0;
    bus.HWDATA = 64'hDEADDEADDEADDEAD;
    hready_block = 1'b0;
    @(negedge HCLK);
    check_eq("blocked_hreadyout", 64'(bus.HREADYOUT), 64'd1);
    @(posedge HCLK); #1;
    set_beat(0, 1'b0, 64'h0, 3'd3, 64'h0); run_beats(1);
    check_eq("blocked_ram_unchanged", r_data[0], 64'h0123456789ABCDEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
